// File: rtl/hand_motion_arbiter.sv
// Hand motion arbiter: merges flexor/extensor window decisions into a single
// open/close command for the shared hand motor.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_OPEN    | hand at rest, fully open; waits for close request and no lock
// S_CLOSING | motor driving toward closed; pauses on conflict; may reverse
// S_CLOSED  | hand at rest, fully closed; waits for open request and no lock
// S_OPENING | motor driving toward open; pauses on conflict; may reverse
module hand_motion_arbiter #(
  parameter int unsigned     CW         = 24,
  parameter logic [CW-1:0]   TRAVEL_CYC = 24'd5_000_000,
  parameter logic [CW-1:0]   LOCK_CYC   = 24'd2_500_000,
  parameter logic [CW-1:0]   STALE_CYC  = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flex_ctrl,
  input  logic       flex_wr,
  input  logic       ext_ctrl,
  input  logic       ext_wr,
  input  logic       limit_close,
  input  logic       limit_open,
  output logic       motor_en,
  output logic       motor_dir,
  output logic [1:0] hand_state,
  output logic       conflict,
  output logic       locked
);

  typedef enum logic [1:0] {
    S_OPEN    = 2'b00,
    S_CLOSING = 2'b01,
    S_CLOSED  = 2'b10,
    S_OPENING = 2'b11
  } state_t;

  state_t        r_state;
  logic          r_flex_act;
  logic          r_ext_act;
  logic [CW-1:0] r_flex_stale;
  logic [CW-1:0] r_ext_stale;
  logic [CW-1:0] r_travel_cnt;
  logic [CW-1:0] r_lock_cnt;

  state_t        w_next_state;
  logic [CW-1:0] w_travel_nxt;
  logic [CW-1:0] w_lock_nxt;
  logic          w_close_req;
  logic          w_open_req;
  logic          w_conflict;
  logic          w_locked;
  logic          w_travel_done;

  assign w_close_req = r_flex_act & ~r_ext_act;
  assign w_open_req  = r_ext_act & ~r_flex_act;
  assign w_conflict  = r_flex_act & r_ext_act;
  assign w_locked    = (r_lock_cnt != '0);
  // A reversal on the very first travel cycle leaves zero distance to cover;
  // treat that like the last cycle so the counter never wraps.
  assign w_travel_done = (r_travel_cnt <= CW'(1));

  // Flexor decision latch with staleness timeout; a strobe beats the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flex_act   <= 1'b0;
      r_flex_stale <= '0;
    end else if (flex_wr) begin
      r_flex_act   <= flex_ctrl;
      r_flex_stale <= '0;
    end else begin
      if (r_flex_stale != STALE_CYC) r_flex_stale <= r_flex_stale + CW'(1);
      if (r_flex_stale == STALE_CYC - CW'(1)) r_flex_act <= 1'b0;
    end
  end

  // Extensor decision latch, identical to and independent of the flexor one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext_act   <= 1'b0;
      r_ext_stale <= '0;
    end else if (ext_wr) begin
      r_ext_act   <= ext_ctrl;
      r_ext_stale <= '0;
    end else begin
      if (r_ext_stale != STALE_CYC) r_ext_stale <= r_ext_stale + CW'(1);
      if (r_ext_stale == STALE_CYC - CW'(1)) r_ext_act <= 1'b0;
    end
  end

  // State, travel and lockout registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_OPEN;
      r_travel_cnt <= '0;
      r_lock_cnt   <= '0;
    end else begin
      r_state      <= w_next_state;
      r_travel_cnt <= w_travel_nxt;
      r_lock_cnt   <= w_lock_nxt;
    end
  end

  // Next-state, travel countdown and lockout load/decrement.
  always_comb begin
    w_next_state = r_state;
    w_travel_nxt = r_travel_cnt;
    w_lock_nxt   = w_locked ? (r_lock_cnt - CW'(1)) : r_lock_cnt;
    case (r_state)
      S_OPEN: begin
        if (w_close_req && !w_locked) begin
          if (limit_close) begin
            w_next_state = S_CLOSED;
            w_lock_nxt   = LOCK_CYC;
          end else begin
            w_next_state = S_CLOSING;
            w_travel_nxt = TRAVEL_CYC;
          end
        end
      end
      S_CLOSING: begin
        if (!w_conflict) begin
          if (limit_close || w_travel_done) begin
            w_next_state = S_CLOSED;
            w_lock_nxt   = LOCK_CYC;
            w_travel_nxt = '0;
          end else if (w_open_req) begin
            w_next_state = S_OPENING;
            w_travel_nxt = TRAVEL_CYC - r_travel_cnt;
          end else begin
            w_travel_nxt = r_travel_cnt - CW'(1);
          end
        end
      end
      S_CLOSED: begin
        if (w_open_req && !w_locked) begin
          if (limit_open) begin
            w_next_state = S_OPEN;
            w_lock_nxt   = LOCK_CYC;
          end else begin
            w_next_state = S_OPENING;
            w_travel_nxt = TRAVEL_CYC;
          end
        end
      end
      S_OPENING: begin
        if (!w_conflict) begin
          if (limit_open || w_travel_done) begin
            w_next_state = S_OPEN;
            w_lock_nxt   = LOCK_CYC;
            w_travel_nxt = '0;
          end else if (w_close_req) begin
            w_next_state = S_CLOSING;
            w_travel_nxt = TRAVEL_CYC - r_travel_cnt;
          end else begin
            w_travel_nxt = r_travel_cnt - CW'(1);
          end
        end
      end
      default: w_next_state = S_OPEN;
    endcase
  end

  assign motor_en   = ((r_state == S_CLOSING) || (r_state == S_OPENING)) && !w_conflict;
  assign motor_dir  = (r_state == S_CLOSING) || (r_state == S_CLOSED);
  assign hand_state = r_state;
  assign conflict   = w_conflict;
  assign locked     = w_locked;

endmodule

// File: doc/hand_motion_arbiter.md
Name: hand_motion_arbiter

Overview:
- Arbitrates decisions from two EMG window-decision units (flexor channel, extensor channel) and drives a single shared hand motor.
- Sequences the motor through open/closing/closed/opening with travel timing, limit-switch termination, mid-travel reversal, post-move lockout, conflict pause and stale-decision timeout.
- Sits between the per-channel decision units (ctrl/wr pulse outputs) and the motor driver H-bridge enable/direction pins.

Parameters:
- CW, 24, width of all internal counters.
- TRAVEL_CYC, 24'd5_000_000, clock cycles for a full open-to-closed or closed-to-open travel.
- LOCK_CYC, 24'd2_500_000, lockout cycles after a move completes, during which no new move starts.
- STALE_CYC, 24'd10_000_000, cycles without a wr pulse on a channel before that channel's latched decision is cleared.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- flex_ctrl  in  1  flexor decision level, valid when flex_wr=1.
- flex_wr  in  1  one-cycle strobe; latch flex_ctrl.
- ext_ctrl  in  1  extensor decision level, valid when ext_wr=1.
- ext_wr  in  1  one-cycle strobe; latch ext_ctrl.
- limit_close  in  1  closed end-stop switch, active-high, synchronous to clk.
- limit_open  in  1  open end-stop switch, active-high, synchronous to clk.
- motor_en  out  1  motor drive enable.
- motor_dir  out  1  1 = close, 0 = open.
- hand_state  out  2  00 OPEN, 01 CLOSING, 10 CLOSED, 11 OPENING.
- conflict  out  1  both latched decisions active.
- locked  out  1  lockout counter nonzero.

Behaviour:
- Reset (async, any time including mid-travel):
  - state = OPEN; flex_act = ext_act = 0; travel_cnt = lock_cnt = 0; both stale counters = 0.
  - Outputs: motor_en = 0, motor_dir = 0, hand_state = 00, conflict = 0, locked = 0.
- Latching:
  - On the edge where flex_wr=1: flex_act <= flex_ctrl and flex stale counter <= 0. Otherwise the flex stale counter increments, saturating at STALE_CYC. On reaching STALE_CYC, flex_act <= 0.
  - ext channel is identical and independent. Simultaneous strobes on both channels are both taken in the same cycle.
  - A wr on the same edge that staleness triggers wins: the strobed value is latched.
- Decoded requests (from registers only):
  - close_req = flex_act & ~ext_act
  - open_req = ext_act & ~flex_act
  - conflict = flex_act & ext_act
- Outputs are combinational decodes of registers only; there is no input-to-output path.
  - motor_en = (CLOSING or OPENING) & ~conflict.
  - motor_dir = 1 in CLOSING and CLOSED, 0 otherwise.
  - locked = (lock_cnt != 0).
- Latency: a wr sampled at edge N updates the act register at N. The state changes at edge N+1, so motor_en rises after edge N+1.
- lock_cnt decrements by 1 each cycle while nonzero and never wraps below 0.
- OPEN state:
  - close_req & ~locked & ~limit_close -> CLOSING, travel_cnt <= TRAVEL_CYC.
  - close_req & ~locked & limit_close -> CLOSED directly, lock_cnt <= LOCK_CYC, no motor pulse.
  - Otherwise stay.
- CLOSING state:
  - conflict: pause. travel_cnt is frozen, motor_en = 0, state is held.
  - Otherwise, the following priorities apply:
    1. limit_close or travel_cnt == 1 -> CLOSED, lock_cnt <= LOCK_CYC, travel_cnt <= 0.
    2. open_req -> OPENING, travel_cnt <= TRAVEL_CYC - travel_cnt (elapsed distance). No lockout applies to a reversal.
    3. Else travel_cnt decrements.
  - limit_open is ignored in CLOSING.
- CLOSED state: mirror of OPEN, using open_req, limit_open and the OPENING target.
- OPENING state: mirror of CLOSING, using limit_open, close_req, the OPEN target and the reversal to CLOSING.
- Both latched decisions low during travel: motion continues to completion. Only the opposite request reverses it.
- Width rule: all counters are CW bits, unsigned. Parameters must satisfy 1 <= value < 2^CW.

Test Plan (TRAVEL_CYC=10, LOCK_CYC=4, STALE_CYC=50):
- Reset, then flex_wr pulse with flex_ctrl=1 -> motor_en=1 and motor_dir=1 two edges later; hand_state=01 for exactly 10 cycles; then hand_state=10, motor_en=0, locked=1 for 4 cycles.
- During closing (cycle 3 of travel), ext_wr with ext_ctrl=1 and flex_wr with flex_ctrl=0 in the same cycle -> hand_state=11 and motor_dir=0; opening lasts exactly 3 cycles, then OPEN with lock.
- From CLOSED, ext request issued while locked=1 -> no move until lock_cnt reaches 0; OPENING starts on the following edge.
- Closing with both channels latched active -> conflict=1, motor_en=0, travel_cnt frozen; clearing ext resumes closing for the remaining cycles only.
- Closing with limit_close asserted at cycle 5 -> CLOSED on the next edge. In OPEN, flex request with limit_close already high -> CLOSED immediately with motor_en never asserted.
- Single flex_wr=1, then no strobes for 50 cycles -> flex_act clears. Assert reset mid-OPENING -> all outputs 0 and hand_state=00 immediately (asynchronous).
